difftest_aia_event_tx: RTL
==========================

# difftest_aia_event_tx

Producer side of the DiffTest AIA sync-event channel. Samples the hart's AIA interrupt-state CSRs (mtopei, stopei, vstopei, hgeip) every cycle and detects changes. It snapshots each change, buffers the snapshots in a small FIFO, and emits one event per cycle toward the DPI sync-event sink. The sink only accepts events while the difftest flow control grants them, so the block absorbs bursts and reports any loss.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of the drop counter

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_mtopei  in  64  current mtopei value from CSR file
- in_stopei  in  64  current stopei value
- in_vstopei  in  64  current vstopei value
- in_hgeip  in  64  current hgeip value
- in_coreid  in  8  hart id, static after reset
- force_sync  in  1  push a snapshot this cycle even if nothing changed
- sink_ready  in  1  difftest flow control; event may be issued next cycle
- out_valid  out  1  event present; drives sink enable/valid
- out_mtopei, out_stopei, out_vstopei, out_hgeip  out  64 each  event payload
- out_coreid  out  8  event hart id
- overflow  out  1  sticky; a snapshot was dropped since reset
- drop_count  out  CNT_W  saturating count of dropped snapshots
- fifo_count  out  log2(DEPTH)+1  current occupancy, for debug/perf

## Operation

- Reset state:
  - prev_* registers are 0.
  - FIFO is empty.
  - out_valid is 0 and all out_* payloads are 0.
  - overflow is 0, drop_count is 0, fifo_count is 0.
- Change detect:
  - change = (in_X != prev_X) for any of the four CSRs.
  - prev_X <= in_X on every non-reset edge.
  - The first cycle after reset with any nonzero CSR therefore fires.
- push = change | force_sync. A push writes the full snapshot {mtopei, stopei, vstopei, hgeip, coreid} from that cycle's inputs.
- pop = FIFO non-empty & sink_ready. A pop loads the head entry into the out_* registers and sets out_valid = 1.
- When there is no pop, out_valid = 0 next cycle. out_* payloads hold their last values and are don't-care while out_valid = 0.
- Each pop produces exactly one out_valid cycle. There is no hold or retry: the sink consumes the event unconditionally.
- No bypass: a snapshot pushed in cycle N can pop no earlier than cycle N+1.
- Full handling:
  - Full with push and pop in the same cycle: both take effect, occupancy is unchanged, nothing is dropped.
  - Full with push and no pop: the new snapshot is dropped, overflow <= 1, and drop_count increments, saturating at all-ones. FIFO contents are unchanged (oldest events are preserved).
- Empty with push and sink_ready in the same cycle: the push is accepted and no pop occurs, because the FIFO was empty at the edge.
- Pointers are log2(DEPTH) wide and wrap modulo DEPTH. Occupancy is tracked separately; full is count == DEPTH, empty is count == 0.
- Reset asserted mid-operation: all queued events are discarded and every register returns to its reset value on that edge. No event issues in the cycle following reset.
- No coalescing: back-to-back changes produce back-to-back entries in order.

## Timing

- Change sampled at edge N, entry valid after edge N, popped at edge N+1 (if sink_ready in cycle N+1), out_valid high during cycle N+2. Minimum latency is 2 cycles.
- Sustained throughput is 1 event per cycle while sink_ready stays high.
- fifo_count, overflow, and drop_count are registered and update on the same edge as the push or pop that changes them.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset, then in_mtopei = 0x0000_0000_000B_000B in cycle 3, sink_ready = 1 throughout:
  - out_valid is high only in cycle 5 with out_mtopei = 0x000B000B and the other payloads 0.
  - drop_count = 0.
- Four consecutive cycles with in_hgeip = 1, 2, 3, 4, sink_ready = 1:
  - Four consecutive out_valid cycles with out_hgeip = 1, 2, 3, 4 in order.
- sink_ready = 0 and six distinct in_stopei changes (DEPTH = 4):
  - fifo_count = 4.
  - overflow = 1 and drop_count = 2.
  - After sink_ready = 1, exactly four events issue carrying the first four values.
- FIFO full, then push and sink_ready in the same cycle:
  - fifo_count stays 4 and drop_count is unchanged.
  - The fifth value issues as the last of five events.
- force_sync = 1 with static inputs (coreid = 0x02, all CSRs 0x55):
  - One event with out_coreid = 0x02 and all payloads 0x55 (plus the initial change event).
- Three entries queued, reset pulsed for one cycle with sink_ready = 1:
  - out_valid stays 0 after reset.
  - fifo_count = 0 and overflow = 0.
  - No stale event ever appears.

Source files
------------

// File: rtl/difftest_aia_event_tx.sv
`default_nettype none
// ============================================================================
// Module      : difftest_aia_event_tx
// Description : Producer side of the DiffTest AIA sync-event channel.
//               Watches the hart's AIA interrupt-state CSRs (mtopei, stopei,
//               vstopei, hgeip), snapshots every change (or a forced sync),
//               queues snapshots in a small FIFO and issues at most one
//               event per cycle while the sink grants flow control.
//               Snapshots arriving while the queue is full are dropped and
//               accounted for in a sticky overflow flag and a saturating
//               drop counter.
//
// Ports       :
//   clock        in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   in_mtopei    in   [63:0] current mtopei
//   in_stopei    in   [63:0] current stopei
//   in_vstopei   in   [63:0] current vstopei
//   in_hgeip     in   [63:0] current hgeip
//   in_coreid    in   [7:0]  hart id
//   force_sync   in   push a snapshot even without a change
//   sink_ready   in   sink grant; an event may issue next cycle
//   out_valid    out  event present this cycle
//   out_mtopei / out_stopei / out_vstopei / out_hgeip  out [63:0] payload
//   out_coreid   out  [7:0] event hart id
//   overflow     out  sticky: a snapshot was dropped since reset
//   drop_count   out  [CNT_W-1:0] saturating dropped-snapshot count
//   fifo_count   out  [log2(DEPTH):0] current occupancy
//
// Revision    : 1.0 - initial release
// ============================================================================
module difftest_aia_event_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              in_mtopei,
  input  logic [63:0]              in_stopei,
  input  logic [63:0]              in_vstopei,
  input  logic [63:0]              in_hgeip,
  input  logic [7:0]               in_coreid,
  input  logic                     force_sync,
  input  logic                     sink_ready,
  output logic                     out_valid,
  output logic [63:0]              out_mtopei,
  output logic [63:0]              out_stopei,
  output logic [63:0]              out_vstopei,
  output logic [63:0]              out_hgeip,
  output logic [7:0]               out_coreid,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_cnt_w   = c_ptr_w + 1;
  localparam int c_entry_w = 4 * 64 + 8;

  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [CNT_W-1:0]   c_drp_one = CNT_W'(1);

  // Change detection state
  logic [63:0] r_prev_mtopei;
  logic [63:0] r_prev_stopei;
  logic [63:0] r_prev_vstopei;
  logic [63:0] r_prev_hgeip;

  // FIFO storage and bookkeeping
  logic [c_entry_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  // Output registers
  logic                 r_out_valid;
  logic [c_entry_w-1:0] r_out_entry;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_drop_count;

  logic                 w_change;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr;
  logic                 w_drop;
  logic [c_entry_w-1:0] w_snapshot;

  assign w_change = (in_mtopei  != r_prev_mtopei)  |
                    (in_stopei  != r_prev_stopei)  |
                    (in_vstopei != r_prev_vstopei) |
                    (in_hgeip   != r_prev_hgeip);

  assign w_push     = w_change | force_sync;
  assign w_full     = (r_count == c_full);
  assign w_empty    = (r_count == '0);
  // Pop decision uses occupancy at the edge, so a same-cycle push into an
  // empty FIFO cannot bypass straight to the output.
  assign w_pop      = ~w_empty & sink_ready;
  // When full, a simultaneous pop frees the head slot, so the push still fits.
  assign w_wr       = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;
  assign w_snapshot = {in_mtopei, in_stopei, in_vstopei, in_hgeip, in_coreid};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_mtopei  <= '0;
      r_prev_stopei  <= '0;
      r_prev_vstopei <= '0;
      r_prev_hgeip   <= '0;
    end else begin
      r_prev_mtopei  <= in_mtopei;
      r_prev_stopei  <= in_stopei;
      r_prev_vstopei <= in_vstopei;
      r_prev_hgeip   <= in_hgeip;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (!reset && w_wr) begin
      r_mem[r_wr_ptr] <= w_snapshot;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_entry <= '0;
    end else begin
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out_entry <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + c_drp_one;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_mtopei  = r_out_entry[c_entry_w-1 -: 64];
  assign out_stopei  = r_out_entry[c_entry_w-65 -: 64];
  assign out_vstopei = r_out_entry[c_entry_w-129 -: 64];
  assign out_hgeip   = r_out_entry[c_entry_w-193 -: 64];
  assign out_coreid  = r_out_entry[7:0];
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;
  assign fifo_count  = r_count;

endmodule
`default_nettype wire
